ghost_mover: RTL
================

Name: ghost_mover

Overview:
- Downstream stage of the per-ghost targeting and behaviour logic.
- Consumes the per-tile direction decision `dirToMove` together with the wall flags.
- Advances the ghost across the maze grid in sub-tile steps, paced by a movement tick.
- Publishes the ghost tile position and heading to the renderer and to the next behaviour evaluation, and flags a pac-man catch.

Parameters:
- GRID_W, 28, maze width in tiles.
- GRID_H, 31, maze height in tiles.
- POS_W, 5, width of the tile coordinates.
- STEPS_PER_TILE, 4, ticks needed to cross one tile (must be 2..16).
- START_X, 13, reset tile column.
- START_Y, 11, reset tile row.
- TUNNEL_Y, 14, row on which left/right wrap-around is permitted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle movement enable pulse.
- freeze  in  1  holds all state while high; tick is ignored.
- dirToMove  in  2  requested direction: 00 up, 01 right, 10 down, 11 left.
- canMoveU, canMoveR, canMoveD, canMoveL  in  1 each  the neighbouring tile of the current tile is open.
- pacPosX, pacPosY  in  POS_W each  pac-man tile position.
- ghostPosX, ghostPosY  out  POS_W each  registered ghost tile position.
- ghostDir  out  2  registered current heading.
- moving  out  1  high while between tiles (state STEP).
- subStep  out  $clog2(STEPS_PER_TILE)  sub-tile offset, for smooth rendering.
- caught  out  1  one-cycle pulse when the ghost tile equals the pac-man tile.

Behaviour:

Reset values:
- ghostPosX=START_X, ghostPosY=START_Y.
- ghostDir=11 (left).
- subStep=0, moving=0, caught=0.
- State is IDLE.

State IDLE (ghost centred on a tile):
- Acts only on a tick with freeze=0.
- If the flag for dirToMove is 1: ghostDir<=dirToMove, go to STEP, subStep<=1.
- Else if the flag for the current ghostDir is 1: keep ghostDir, go to STEP, subStep<=1.
- Else: stay in IDLE; ghostDir is unchanged.

State STEP (ghost between tiles):
- dirToMove and the canMove flags are ignored; the direction is committed until the next tile centre.
- On each tick with subStep < STEPS_PER_TILE-1: subStep<=subStep+1.
- On the tick with subStep = STEPS_PER_TILE-1:
  - Update the tile position by one in ghostDir.
  - subStep<=0, return to IDLE.
  - Net cost: STEPS_PER_TILE ticks per tile.

Position arithmetic (registered; outputs change the cycle after the final tick):
- Up: Y-1. Down: Y+1. Right: X+1. Left: X-1.
- Wrap applies only when ghostPosY=TUNNEL_Y:
  - Left from X=0 gives X=GRID_W-1.
  - Right from X=GRID_W-1 gives X=0.
- Off the tunnel row, or on any vertical move, a move past a grid edge saturates at 0, GRID_W-1 or GRID_H-1. This is a defensive clamp; the wall flags normally prevent it.

Outputs:
- moving = (state==STEP).

Catch detection:
- match = (ghostPosX==pacPosX && ghostPosY==pacPosY), evaluated every cycle, including while frozen.
- caught is registered and pulses high for exactly one cycle on a 0-to-1 transition of match.
- A sustained overlap does not re-pulse.
- If match is already 1 on the first cycle after reset deassertion, caught pulses once.

Freeze:
- Holds state, position and subStep even if freeze asserts in mid-STEP.
- Resumes on the next tick after freeze deasserts.

Reset mid-STEP:
- Immediately returns to IDLE at the start tile.
- Any partial step is discarded.

Decomposition:
- Shared package ghost_pkg holds:
  - the direction typedef dir_t (UP=2'b00, RIGHT=2'b01, DOWN=2'b10, LEFT=2'b11);
  - the state typedef mover_state_t (IDLE, STEP);
  - the GRID_W, GRID_H, POS_W and TUNNEL_Y defaults.
- One sub-module is natural: grid_step, a combinational next-tile calculator (position, direction → new position, including wrap and clamp). It is reused later by the pac-man mover.

Test Plan:
1. Reset, then 4 ticks with dirToMove=01, canMoveR=1 → moving is 1 for ticks 1–3; subStep goes 1,2,3,0; ghostPosX goes 13→14 one cycle after tick 4; ghostDir=01.
2. IDLE, dirToMove=00 with canMoveU=0, ghostDir=11 with canMoveL=1 → ghost continues left; X decrements after 4 ticks; ghostDir stays 11.
3. All canMove flags=0, 10 ticks → position unchanged, moving=0, ghostDir unchanged.
4. Ghost at (0,14) heading left with canMoveL=1, 4 ticks → X=27, Y=14. The same move at (0,5) saturates at X=0.
5. Freeze asserted after the 2nd of 4 ticks; 5 ticks arrive while frozen → subStep holds at 2. After release, 2 more ticks complete the tile.
6. pac at (14,11), ghost moves 13→14 → caught is high for exactly 1 cycle; it stays low for 20 further cycles of overlap. Reset asserted mid-STEP → ghostPos=(13,11), subStep=0, moving=0 on the same cycle.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared types and maze defaults for the ghost/pac-man movement logic.
package ghost_pkg;

    // Heading encoding shared with the targeting logic and the renderer.
    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    // IDLE: centred on a tile. STEP: committed to crossing into the next tile.
    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } mover_state_t;

    localparam int GRID_W   = 28;
    localparam int GRID_H   = 31;
    localparam int POS_W    = 5;
    localparam int TUNNEL_Y = 14;

endpackage : ghost_pkg

// File: rtl/grid_step.sv
// Combinational next-tile calculator: one tile in the given heading, with
// left/right wrap on the tunnel row and saturation at every other grid edge.
module grid_step
    import ghost_pkg::*;
#(
    parameter int GRID_W   = ghost_pkg::GRID_W,
    parameter int GRID_H   = ghost_pkg::GRID_H,
    parameter int POS_W    = ghost_pkg::POS_W,
    parameter int TUNNEL_Y = ghost_pkg::TUNNEL_Y
) (
    input  logic [POS_W-1:0] pos_x_i,
    input  logic [POS_W-1:0] pos_y_i,
    input  dir_t             dir_i,
    output logic [POS_W-1:0] pos_x_o,
    output logic [POS_W-1:0] pos_y_o
);

    localparam logic [POS_W-1:0] X_MAX  = POS_W'(GRID_W - 1);
    localparam logic [POS_W-1:0] Y_MAX  = POS_W'(GRID_H - 1);
    localparam logic [POS_W-1:0] TUNNEL = POS_W'(TUNNEL_Y);
    localparam logic [POS_W-1:0] ZERO   = '0;
    localparam logic [POS_W-1:0] ONE    = POS_W'(1);

    logic on_tunnel;
    assign on_tunnel = (pos_y_i == TUNNEL);

    // Move one tile; edges clamp defensively, except horizontal wrap in the tunnel.
    always_comb begin
        pos_x_o = pos_x_i;
        pos_y_o = pos_y_i;
        unique case (dir_i)
            UP: begin
                pos_y_o = (pos_y_i == ZERO) ? ZERO : pos_y_i - ONE;
            end
            DOWN: begin
                pos_y_o = (pos_y_i >= Y_MAX) ? Y_MAX : pos_y_i + ONE;
            end
            RIGHT: begin
                if (pos_x_i >= X_MAX) begin
                    pos_x_o = on_tunnel ? ZERO : X_MAX;
                end else begin
                    pos_x_o = pos_x_i + ONE;
                end
            end
            LEFT: begin
                if (pos_x_i == ZERO) begin
                    pos_x_o = on_tunnel ? X_MAX : ZERO;
                end else begin
                    pos_x_o = pos_x_i - ONE;
                end
            end
            default: ;
        endcase
    end

endmodule : grid_step

// File: rtl/ghost_mover.sv
// Ghost movement stage: turns per-tile direction decisions into tile-by-tile
// motion paced by a movement tick, and flags a catch of pac-man.
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int GRID_W         = ghost_pkg::GRID_W,
    parameter int GRID_H         = ghost_pkg::GRID_H,
    parameter int POS_W          = ghost_pkg::POS_W,
    parameter int STEPS_PER_TILE = 4,
    parameter int START_X        = 13,
    parameter int START_Y        = 11,
    parameter int TUNNEL_Y       = ghost_pkg::TUNNEL_Y,
    localparam int SUB_W         = $clog2(STEPS_PER_TILE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             freeze,
    input  logic [1:0]       dirToMove,
    input  logic             canMoveU,
    input  logic             canMoveR,
    input  logic             canMoveD,
    input  logic             canMoveL,
    input  logic [POS_W-1:0] pacPosX,
    input  logic [POS_W-1:0] pacPosY,
    output logic [POS_W-1:0] ghostPosX,
    output logic [POS_W-1:0] ghostPosY,
    output logic [1:0]       ghostDir,
    output logic             moving,
    output logic [SUB_W-1:0] subStep,
    output logic             caught
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_TILE - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);

    mover_state_t     state_q, state_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    dir_t             dir_q, dir_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             match_prev_q;
    logic             caught_q;

    logic [POS_W-1:0] step_x, step_y;
    logic [3:0]       can_move;
    dir_t             req_dir;
    logic             advance;
    logic             match;

    // Open-neighbour flags indexed by heading encoding.
    assign can_move = {canMoveL, canMoveD, canMoveR, canMoveU};
    assign req_dir  = dir_t'(dirToMove);
    assign advance  = tick & ~freeze;

    grid_step #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .POS_W    (POS_W),
        .TUNNEL_Y (TUNNEL_Y)
    ) u_grid_step (
        .pos_x_i (pos_x_q),
        .pos_y_i (pos_y_q),
        .dir_i   (dir_q),
        .pos_x_o (step_x),
        .pos_y_o (step_y)
    );

    // Next-state: pick a heading at tile centres, then count sub-steps to the next tile.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_d   = dir_q;
        sub_d   = sub_q;
        if (advance) begin
            unique case (state_q)
                IDLE: begin
                    if (can_move[req_dir]) begin
                        dir_d   = req_dir;
                        state_d = STEP;
                        sub_d   = SUB_ONE;
                    end else if (can_move[dir_q]) begin
                        state_d = STEP;
                        sub_d   = SUB_ONE;
                    end
                end
                STEP: begin
                    if (sub_q == SUB_LAST) begin
                        pos_x_d = step_x;
                        pos_y_d = step_y;
                        sub_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sub_d = sub_q + SUB_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Movement state registers; reset drops any partial step at the start tile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_x_q <= POS_W'(START_X);
            pos_y_q <= POS_W'(START_Y);
            dir_q   <= LEFT;
            sub_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_q   <= dir_d;
            sub_q   <= sub_d;
        end
    end

    // Catch is edge-detected on tile overlap; it runs even while frozen.
    assign match = (pos_x_q == pacPosX) && (pos_y_q == pacPosY);

    // Previous-match flag starts at 0 so an overlap present right after reset still pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_prev_q <= 1'b0;
            caught_q     <= 1'b0;
        end else begin
            match_prev_q <= match;
            caught_q     <= match & ~match_prev_q;
        end
    end

    assign ghostPosX = pos_x_q;
    assign ghostPosY = pos_y_q;
    assign ghostDir  = dir_q;
    assign moving    = (state_q == STEP);
    assign subStep   = sub_q;
    assign caught    = caught_q;

endmodule : ghost_mover
